// File: rtl/adc_serial_reader.sv
// Serial front end for a 3-wire ADC0831-style converter: drives cs_n/sclk,
// skips LEAD lead-in periods, shifts in NBITS data bits MSB first, strobes valid.
module adc_serial_reader #(
  parameter int unsigned DIV   = 2,
  parameter int unsigned NBITS = 8,
  parameter int unsigned LEAD  = 1,
  parameter int unsigned GAP   = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             adc_do,
  output logic             cs_n,
  output logic             sclk,
  output logic [NBITS-1:0] data,
  output logic             valid,
  output logic             busy
);

  localparam int unsigned CW      = 16;
  localparam int unsigned PERIODS = LEAD + NBITS;
  localparam int unsigned PW      = $clog2(PERIODS + 1);
  localparam int unsigned PW1     = PW + 1;

  localparam logic [CW-1:0]  HALF_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]  GAP_LAST  = CW'(GAP);
  localparam logic [PW-1:0]  PER_LAST  = PW'(PERIODS - 1);
  localparam logic [PW1-1:0] LEAD_CMP  = PW1'(LEAD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_CLOCK,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    per_q, per_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [NBITS-1:0] shifted;
  logic             is_data;
  logic             cs_n_d, sclk_d, valid_d, busy_d;
  logic [NBITS-1:0] data_d;

  // Lead-in periods (per_q < LEAD) are clocked but never shifted in.
  assign is_data = (({1'b0, per_q} + PW1'(1)) > LEAD_CMP);
  assign shifted = NBITS'({shift_q, adc_do});

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      shift_q <= '0;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      data    <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      shift_q <= shift_d;
      cs_n    <= cs_n_d;
      sclk    <= sclk_d;
      data    <= data_d;
      valid   <= valid_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    shift_d = shift_q;
    cs_n_d  = cs_n;
    sclk_d  = sclk;
    data_d  = data;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        per_d = '0;
        if (en) begin
          state_d = S_SETUP;
          cs_n_d  = 1'b0;
        end
      end

      S_SETUP: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_CLOCK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // adc_do is captured on the edge that ends each sclk high half.
      S_CLOCK: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d  = '0;
          sclk_d = ~sclk;
          if (sclk) begin
            if (is_data) begin
              shift_d = shifted;
            end
            if (per_q == PER_LAST) begin
              state_d = S_GAP;
              sclk_d  = 1'b0;
              cs_n_d  = 1'b1;
              valid_d = 1'b1;
              data_d  = shifted;
            end else begin
              per_d = per_q + PW'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Covers the valid cycle plus GAP further cycles with cs_n high.
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = ~cs_n_d;
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Bench for adc_serial_reader: two instances (DIV=2/LEAD=1 and DIV=1/LEAD=0)
// compared every cycle against a timeline model driven by a serial ADC model.
module tb_adc_serial_reader;

  localparam int NB = 8;
  localparam int GP = 4;

  logic          clk = 1'b0;
  logic          clr      [2];
  logic          en       [2];
  logic          adc_do   [2];
  logic          cs_n     [2];
  logic          sclk     [2];
  logic [NB-1:0] data     [2];
  logic          valid    [2];
  logic          busy     [2];

  int passed = 0;
  int total  = 0;
  bit chk_on = 1'b0;

  // Reference model state: t = cycles since cs_n fell, -1 while idle.
  int            t         [2] = '{-1, -1};
  logic [NB-1:0] word      [2] = '{8'h00, 8'h00};
  logic [NB-1:0] next_word [2] = '{8'h00, 8'h00};
  logic [NB-1:0] exp_data  [2] = '{8'h00, 8'h00};
  logic [7:0]    lead_junk [2] = '{8'h00, 8'h00};

  int adc_idx   [2] = '{0, 0};
  bit adc_psclk [2] = '{1'b0, 1'b0};

  int cyc = 0;
  bit prev_cs    [2] = '{1'b1, 1'b1};
  bit prev_sclk  [2] = '{1'b0, 1'b0};
  int fall_cnt   [2] = '{0, 0};
  int vcount     [2] = '{0, 0};
  int t0         [2] = '{0, 0};
  int rises      [2] = '{0, 0};
  int hi_run     [2] = '{0, 0};
  int hi_last    [2] = '{0, 0};
  int last_lat   [2] = '{0, 0};
  int last_rises [2] = '{0, 0};

  adc_serial_reader #(.DIV(2), .NBITS(NB), .LEAD(1), .GAP(GP)) u0 (
    .clk(clk), .clr(clr[0]), .en(en[0]), .adc_do(adc_do[0]),
    .cs_n(cs_n[0]), .sclk(sclk[0]), .data(data[0]), .valid(valid[0]), .busy(busy[0])
  );

  adc_serial_reader #(.DIV(1), .NBITS(NB), .LEAD(0), .GAP(GP)) u1 (
    .clk(clk), .clr(clr[1]), .en(en[1]), .adc_do(adc_do[1]),
    .cs_n(cs_n[1]), .sclk(sclk[1]), .data(data[1]), .valid(valid[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  function automatic int divof(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int leadof(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic int lat(int i);
    return 2 * (leadof(i) + NB) * divof(i);
  endfunction

  // Bit the ADC presents during period k: lead junk, then the word MSB first.
  function automatic logic adc_bit(int i, int k);
    int b;
    b = k - leadof(i);
    if (b < 0 || b > NB - 1) return lead_junk[i][3'(k % 8)];
    return word[i][3'(NB - 1 - b)];
  endfunction

  task automatic check(string nm, int i, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s u%0d: got %0h expected %0h (cycle %0d)", nm, i, act, exp, cyc);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_fall(int i, int base, int budget);
    int n = 0;
    while (fall_cnt[i] <= base && n < budget) begin
      step(1);
      n++;
    end
    check("cs_fall_seen", i, 32'(fall_cnt[i] > base), 32'd1);
  endtask

  task automatic wait_valid(int i, int base, int budget);
    int n = 0;
    while (vcount[i] <= base && n < budget) begin
      step(1);
      n++;
    end
    check("valid_seen", i, 32'(vcount[i] > base), 32'd1);
  endtask

  // Timeline model: a conversion is LAT low cycles, a valid cycle, GAP cycles, then idle.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr[i]) begin
        t[i]        = -1;
        exp_data[i] = '0;
      end else if (t[i] < 0) begin
        if (en[i]) begin
          t[i]         = 0;
          word[i]      = next_word[i];
          lead_junk[i] = 8'($urandom);
        end
      end else if (t[i] == lat(i) + GP) begin
        t[i] = -1;
      end else begin
        t[i]++;
        if (t[i] == lat(i)) exp_data[i] = word[i];
      end
    end
  end

  // ADC model, DUT event observers and the per-cycle compare.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      bit conv;
      bit exp_sclk;
      if (cs_n[i] !== 1'b0) adc_idx[i] = 0;
      else if (adc_psclk[i] && !sclk[i]) adc_idx[i]++;
      adc_psclk[i] = sclk[i];
      adc_do[i]    = adc_bit(i, adc_idx[i]);

      if (prev_cs[i] && cs_n[i] === 1'b0) begin
        fall_cnt[i]++;
        t0[i]      = cyc;
        rises[i]   = 0;
        hi_last[i] = hi_run[i];
      end
      if (cs_n[i] === 1'b1) hi_run[i]++;
      else hi_run[i] = 0;
      if (!prev_sclk[i] && sclk[i] === 1'b1) rises[i]++;
      if (valid[i] === 1'b1) begin
        vcount[i]++;
        last_lat[i]   = cyc - t0[i];
        last_rises[i] = rises[i];
      end
      prev_cs[i]   = (cs_n[i] === 1'b1);
      prev_sclk[i] = (sclk[i] === 1'b1);

      if (chk_on) begin
        conv     = (t[i] >= 0) && (t[i] < lat(i));
        exp_sclk = conv && (t[i] >= divof(i)) && (((t[i] - divof(i)) / divof(i)) % 2 == 0);
        check("cs_n",  i, 32'(cs_n[i]),  32'(!conv));
        check("busy",  i, 32'(busy[i]),  32'(conv));
        check("sclk",  i, 32'(sclk[i]),  32'(exp_sclk));
        check("valid", i, 32'(valid[i]), 32'(t[i] == lat(i)));
        check("data",  i, 32'(data[i]),  32'(exp_data[i]));
      end
    end
  end

  initial begin
    int f;
    int v;
    for (int i = 0; i < 2; i++) begin
      clr[i] = 1'b1;
      en[i]  = 1'b0;
    end
    step(3);
    chk_on = 1'b1;
    check("rst_cs_n",  0, 32'(cs_n[0]),  32'd1);
    check("rst_sclk",  0, 32'(sclk[0]),  32'd0);
    check("rst_data",  0, 32'(data[0]),  32'h00);
    check("rst_valid", 0, 32'(valid[0]), 32'd0);
    check("rst_busy",  0, 32'(busy[0]),  32'd0);
    clr[0] = 1'b0;
    clr[1] = 1'b0;
    step(2);

    // Single conversion, 0xA5.
    f = fall_cnt[0]; v = vcount[0];
    next_word[0] = 8'hA5;
    en[0] = 1'b1; step(1); en[0] = 1'b0;
    wait_fall(0, f, 10);
    wait_valid(0, v, 100);
    check("single_lat",   0, 32'(last_lat[0]),   32'd36);
    check("single_rises", 0, 32'(last_rises[0]), 32'd9);
    check("single_data",  0, 32'(data[0]),       32'hA5);
    step(3);
    check("single_cs_hi", 0, 32'(cs_n[0]), 32'd1);
    step(5);

    // Continuous mode: 0x3C then 0xFF with en held high.
    f = fall_cnt[0]; v = vcount[0];
    next_word[0] = 8'h3C;
    en[0] = 1'b1;
    wait_fall(0, f, 10);
    next_word[0] = 8'hFF;
    wait_valid(0, v, 100);
    check("cont_data0", 0, 32'(data[0]), 32'h3C);
    f = fall_cnt[0]; v = vcount[0];
    wait_fall(0, f, 20);
    check("cont_gap", 0, 32'(hi_last[0]), 32'd6);
    en[0] = 1'b0;
    wait_valid(0, v, 100);
    check("cont_data1", 0, 32'(data[0]), 32'hFF);
    step(10);

    // Abort with clr at T+20.
    f = fall_cnt[0];
    next_word[0] = 8'h5A;
    en[0] = 1'b1;
    wait_fall(0, f, 10);
    en[0] = 1'b0;
    step(20);
    clr[0] = 1'b1;
    step(1);
    clr[0] = 1'b0;
    check("abort_cs_n", 0, 32'(cs_n[0]), 32'd1);
    check("abort_sclk", 0, 32'(sclk[0]), 32'd0);
    check("abort_data", 0, 32'(data[0]), 32'h00);
    v = vcount[0];
    step(80);
    check("abort_novalid", 0, 32'(vcount[0]), 32'(v));

    // en dropped at T+5: conversion still completes, no new one.
    f = fall_cnt[0]; v = vcount[0];
    next_word[0] = 8'hC3;
    en[0] = 1'b1;
    wait_fall(0, f, 10);
    step(5);
    en[0] = 1'b0;
    wait_valid(0, v, 100);
    check("endrop_lat",  0, 32'(last_lat[0]), 32'd36);
    check("endrop_data", 0, 32'(data[0]),     32'hC3);
    v = vcount[0];
    step(40);
    check("endrop_once", 0, 32'(vcount[0]), 32'(v));
    check("endrop_cs",   0, 32'(cs_n[0]),   32'd1);

    // DIV=1, LEAD=0 boundary: 0x01 then 0x80 pins bit order.
    for (int k = 0; k < 2; k++) begin
      f = fall_cnt[1]; v = vcount[1];
      next_word[1] = (k == 0) ? 8'h01 : 8'h80;
      en[1] = 1'b1; step(1); en[1] = 1'b0;
      wait_fall(1, f, 10);
      wait_valid(1, v, 60);
      check("div1_lat",   1, 32'(last_lat[1]),   32'd16);
      check("div1_rises", 1, 32'(last_rises[1]), 32'd8);
      check("div1_data",  1, 32'(data[1]),       (k == 0) ? 32'h01 : 32'h80);
      step(8);
    end

    // Randomized traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        en[i]        = ($urandom_range(0, 3) != 0);
        next_word[i] = 8'($urandom);
        clr[i]       = ($urandom_range(0, 299) == 0);
      end
      step(1);
    end
    for (int i = 0; i < 2; i++) begin
      en[i]  = 1'b0;
      clr[i] = 1'b0;
    end
    step(100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adc_serial_reader.md
Name: adc_serial_reader

Overview:
- Serial front end for the temperature ADC (ADC0831-style, 3-wire: chip select, serial clock, serial data out).
- Generates cs_n and sclk from clk, discards LEAD null/start bits, then shifts in NBITS data bits MSB first.
- Presents the result as a parallel word with a one-cycle valid strobe.
- Replaces the parallel ADC bus and free-running ADC clock; its data output feeds the ADC transcoder in place of the parallel input.

Parameters:
- DIV, 2: clk cycles per sclk half-period (>=1).
- NBITS, 8: data bits per conversion.
- LEAD, 1: sclk rising edges before the first data bit; their data is ignored (>=0).
- GAP, 4: minimum clk cycles cs_n stays high between conversions, beyond the valid cycle (>=0).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- clr  in  1  synchronous, active-high reset.
- en  in  1  conversion enable, level; sampled only in IDLE.
- adc_do  in  1  serial data from ADC; changes after sclk falling edges.
- cs_n  out  1  ADC chip select, active low.
- sclk  out  1  ADC serial clock.
- data  out  NBITS  last completed conversion result.
- valid  out  1  one-cycle strobe; data updated in the same cycle.
- busy  out  1  high while cs_n is low.

Behaviour:
- Reset (clr=1 at a clk edge): cs_n=1, sclk=0, data=0, valid=0, busy=0, state IDLE, counters cleared.
- clr mid-conversion aborts immediately: no valid, data keeps 0 (reset value), cs_n=1 next cycle.
- States:
  - IDLE: cs_n=1, sclk=0. If en=1, the next cycle is T, the first cycle with cs_n=0; go SETUP.
  - SETUP: sclk=0 for cycles T..T+DIV-1, then go CLOCK.
  - CLOCK: LEAD+NBITS sclk periods, k=0..LEAD+NBITS-1.
    - sclk high in cycles T+DIV+2kDIV .. T+2DIV+2kDIV-1; low for the following DIV cycles.
  - GAP: cs_n=1, sclk=0 for GAP cycles, then IDLE.
- Sampling:
  - adc_do is sampled at the clk edge that drives sclk 1->0, i.e. the end of each high half.
  - Periods k<LEAD are discarded.
  - Periods k>=LEAD shift left into an NBITS shift register; the first data bit ends as the MSB.
- Completion, at the sampling edge of the final period (k=LEAD+NBITS-1):
  - Cycle T+2(LEAD+NBITS)DIV has sclk=0, cs_n=1, busy=0, valid=1, and data = the assembled word including the final bit.
  - The state is GAP from the following cycle.
- Latency: valid occurs 2(LEAD+NBITS)DIV cycles after cs_n falls.
- Minimum cs_n-high time between conversions is 1+GAP+1 cycles: valid cycle, GAP cycles, one IDLE cycle.
- busy equals ~cs_n.
- valid is never high for more than one cycle; data is stable between valid strobes.
- en deasserted mid-conversion: the conversion completes normally; no new one starts.
- en held high: back-to-back conversions separated by the minimum gap.
- A 16-bit half-period counter is sufficient; DIV=1 must work (sclk = clk/2).

Test Plan:
- Reset: hold clr 3 cycles -> cs_n=1, sclk=0, data=0x00, valid=0, busy=0.
- Single conversion (DIV=2, LEAD=1, NBITS=8): ADC model drives lead bit 1 then 0xA5 MSB first, changing on sclk falling edges; en pulse -> cs_n low at T, exactly 9 sclk rising edges, valid=1 with data=0xA5 at T+36, cs_n=1 from T+36.
- Continuous mode, en held high: data 0x3C then 0xFF -> two valid strobes with data=0x3C then 0xFF; cs_n high for exactly 6 cycles between conversions (GAP=4).
- Abort: clr asserted at T+20 -> next cycle cs_n=1, sclk=0, data=0x00; no valid ever asserted for that conversion.
- en dropped at T+5 -> conversion still completes, valid at T+36; cs_n stays high afterwards.
- Boundary, DIV=1, LEAD=0, data 0x01 -> sclk toggles every cycle, valid at T+16, data=0x01; MSB/LSB order confirmed.
